rr_arbiter_4: RTL

Round-robin arbiter that shares one downstream resource among four requesters. It produces a registered one-hot grant, the matching 2-bit binary grant index (the same one-hot to binary mapping as the team's 4-to-2 encoder), and a valid flag. Grants are held while the owner keeps requesting, and are pre-empted after a bounded hold time when another requester is waiting. It sits between the request sources and the shared datapath's select/mux control.

---
 rtl/rr_arbiter_4.sv | 117 +++++++++++
 1 files changed

// File: rtl/rr_arbiter_4.sv
// Round-robin arbiter for four requesters with registered one-hot and binary grant.
// Latency: one cycle from sampled request to visible grant; handover has no gap cycle.
// Backpressure: an owner is pre-empted after MAX_HOLD cycles when others wait; en=0 drops the grant.
//
// Ports:
//   clk, rst_n    rising-edge clock, asynchronous active-low reset
//   en            arbiter enable; low clears the grant and blocks new grants
//   req[3:0]      level-sensitive requests, bit i is requester i
//   gnt[3:0]      registered one-hot grant (0 when idle)
//   gnt_idx[1:0]  binary index of the granted bit (0 when idle)
//   gnt_valid     high exactly when gnt != 0
module rr_arbiter_4 #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state;
    logic [1:0] ptr;
    logic [7:0] hold_cnt;

    // {found, index} of the first requester at or after p, optionally skipping one index.
    function automatic logic [2:0] search(
        input logic [3:0] r,
        input logic [1:0] p,
        input logic       excl_en,
        input logic [1:0] excl
    );
        logic [2:0] result;
        logic [1:0] idx;
        result = 3'b000;
        // Walk from the farthest offset back to ptr so the closest match is written last.
        for (int k = 3; k >= 0; k--) begin
            idx = p + 2'(k);
            if (r[idx] && !(excl_en && (idx == excl))) begin
                result = {1'b1, idx};
            end
        end
        return result;
    endfunction

    logic [2:0] win_all;
    logic [2:0] win_excl;

    always_comb begin
        win_all  = search(req, ptr, 1'b0, 2'b00);
        // The current owner is gnt_idx; excluding it also tells us whether anyone else waits.
        win_excl = search(req, ptr, 1'b1, gnt_idx);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 2'd0;
            hold_cnt  <= 8'd0;
            gnt       <= 4'b0000;
            gnt_idx   <= 2'd0;
            gnt_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (en && win_all[2]) begin
                        state     <= GRANT;
                        gnt       <= 4'b0001 << win_all[1:0];
                        gnt_idx   <= win_all[1:0];
                        gnt_valid <= 1'b1;
                        ptr       <= win_all[1:0] + 2'd1;
                        hold_cnt  <= 8'd0;
                    end
                end
                GRANT: begin
                    if (!en) begin
                        state     <= IDLE;
                        gnt       <= 4'b0000;
                        gnt_idx   <= 2'd0;
                        gnt_valid <= 1'b0;
                    end else if (!req[gnt_idx]) begin
                        if (win_excl[2]) begin
                            gnt      <= 4'b0001 << win_excl[1:0];
                            gnt_idx  <= win_excl[1:0];
                            ptr      <= win_excl[1:0] + 2'd1;
                            hold_cnt <= 8'd0;
                        end else begin
                            state     <= IDLE;
                            gnt       <= 4'b0000;
                            gnt_idx   <= 2'd0;
                            gnt_valid <= 1'b0;
                        end
                    end else if ((hold_cnt == HOLD_LAST) && win_excl[2]) begin
                        gnt      <= 4'b0001 << win_excl[1:0];
                        gnt_idx  <= win_excl[1:0];
                        ptr      <= win_excl[1:0] + 2'd1;
                        hold_cnt <= 8'd0;
                    end else if (hold_cnt != HOLD_LAST) begin
                        // Saturate so a lone owner is pre-empted the moment a rival appears.
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
